// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register write-pending scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to the read ports.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    output logic [DEPTH-1:0]       busy_vec,
    output logic [CW-1:0]          pend_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending, pending_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             wr_ok, iss_ok, cnt_inc, cnt_dec;

    // An address is usable when it exists and is not the hardwired zero register.
    function automatic logic usable(input logic [AW-1:0] a);
        logic in_range;
        in_range = 32'(a) < DEPTH;
        return in_range && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok  = wr_en && usable(wr_addr);
    assign iss_ok = iss_en && usable(iss_addr);

    // Issue is applied after write so a same-address pair leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (wr_ok)
            pending_nxt[wr_addr] = 1'b0;
        if (iss_ok)
            pending_nxt[iss_addr] = 1'b1;
    end

    assign cnt_inc = iss_ok && !pending[iss_addr];
    assign cnt_dec = wr_ok && pending[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

    always_comb begin
        cnt_nxt = cnt;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pending <= '0;
            cnt     <= '0;
        end else begin
            if (wr_ok)
                mem[wr_addr] <= wr_data;
            pending <= pending_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign busy_vec = pending;
    assign pend_cnt = cnt;

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] data;
        logic             busy;

        assign a = rd_addr[p*AW +: AW];

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (usable(a)) begin
                data = mem[a];
                busy = pending[a];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == a)) begin
                data = wr_data;
                busy = 1'b0;
            end
`endif
        end

        assign rd_data[p*WIDTH +: WIDTH] = data;
        assign rd_busy[p]                = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default instance (ZERO_REG=1, 32 regs, 2 ports)
// and a 24-entry, 4-port, ZERO_REG=0 instance for out-of-range and port-aliasing cases.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD0 = 0, K_RD1 = 1, K_BSY = 2, K_BV = 3, K_CNT = 4;
    localparam int K2_RD0 = 5, K2_RD1 = 6, K2_RD2 = 7, K2_RD3 = 8;
    localparam int K2_BSY = 9, K2_BV = 10, K2_CNT = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en, iss_en;
    logic [4:0]  wr_addr, iss_addr;
    logic [31:0] wr_data;
    logic [31:0] busy_vec;
    logic [5:0]  pend_cnt;

    // second instance
    logic [19:0]  rd_addr2;
    logic [127:0] rd_data2;
    logic [3:0]   rd_busy2;
    logic         wr_en2, iss_en2;
    logic [4:0]   wr_addr2, iss_addr2;
    logic [31:0]  wr_data2;
    logic [23:0]  busy_vec2;
    logic [4:0]   pend_cnt2;

    regfile_sb u_dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(busy_vec), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(24), .NREAD(4), .ZERO_REG(0)) u_dut2 (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .iss_en(iss_en2), .iss_addr(iss_addr2),
        .busy_vec(busy_vec2), .pend_cnt(pend_cnt2)
    );

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic string kname(input int k);
        case (k)
            K_RD0:  return "rd_data0";
            K_RD1:  return "rd_data1";
            K_BSY:  return "rd_busy";
            K_BV:   return "busy_vec";
            K_CNT:  return "pend_cnt";
            K2_RD0: return "dut2_rd_data0";
            K2_RD1: return "dut2_rd_data1";
            K2_RD2: return "dut2_rd_data2";
            K2_RD3: return "dut2_rd_data3";
            K2_BSY: return "dut2_rd_busy";
            K2_BV:  return "dut2_busy_vec";
            default: return "dut2_pend_cnt";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RD0:  return rd_data[31:0];
            K_RD1:  return rd_data[63:32];
            K_BSY:  return {30'd0, rd_busy};
            K_BV:   return busy_vec;
            K_CNT:  return {26'd0, pend_cnt};
            K2_RD0: return rd_data2[31:0];
            K2_RD1: return rd_data2[63:32];
            K2_RD2: return rd_data2[95:64];
            K2_RD3: return rd_data2[127:96];
            K2_BSY: return {28'd0, rd_busy2};
            K2_BV:  return {8'd0, busy_vec2};
            default: return {27'd0, pend_cnt2};
        endcase
    endfunction

    task automatic ex(input int k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: all expectations queued for a cycle are checked mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = actual(e.kind);
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", kname(e.kind), act, e.exp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rd_addr = '0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        iss_en = 1'b0; iss_addr = '0;
        rd_addr2 = '0; wr_en2 = 1'b1; wr_addr2 = 5'd5; wr_data2 = 32'hDEADBEEF;
        iss_en2 = 1'b0; iss_addr2 = '0;

        // Reset with a write asserted: nothing survives
        cyc();
        cyc();
        rst = 1'b0; wr_en = 1'b0; wr_en2 = 1'b0;
        rd_addr = {5'd0, 5'd5};
        rd_addr2 = {5'd5, 5'd2, 5'd1, 5'd0};
        ex(K_RD0, 32'h0); ex(K_RD1, 32'h0); ex(K_BSY, 32'h0);
        ex(K_BV, 32'h0); ex(K_CNT, 32'h0);
        ex(K2_RD3, 32'h0); ex(K2_BV, 32'h0); ex(K2_CNT, 32'h0);

        // Issue r3, write it two cycles later
        cyc();
        iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        ex(K_BSY, 32'h0); ex(K_CNT, 32'h0);
        cyc();
        iss_en = 1'b0;
        ex(K_BSY, 32'h1); ex(K_CNT, 32'h1); ex(K_RD0, 32'h0);
        cyc();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
        ex(K_BSY, BYP ? 32'h0 : 32'h1);
        ex(K_RD0, BYP ? 32'h12345678 : 32'h0);
        ex(K_CNT, 32'h1);
        cyc();
        wr_en = 1'b0;
        ex(K_RD0, 32'h12345678); ex(K_BSY, 32'h0);
        ex(K_CNT, 32'h0); ex(K_BV, 32'h0);

        // Hardwired zero register ignores write and issue
        cyc();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd3, 5'd0};
        ex(K_RD0, 32'h0); ex(K_BSY, 32'h0);
        cyc();
        wr_en = 1'b0; iss_en = 1'b0;
        ex(K_RD0, 32'h0); ex(K_RD1, 32'h12345678); ex(K_BSY, 32'h0);
        ex(K_CNT, 32'h0); ex(K_BV, 32'h0);

        // r7 pending, then issue+write r7 together, then plain write
        cyc();
        iss_en = 1'b1; iss_addr = 5'd7; rd_addr = {5'd3, 5'd7};
        cyc();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
        ex(K_CNT, 32'h1);
        cyc();
        wr_en = 1'b0; iss_en = 1'b0;
        ex(K_RD0, 32'hA5); ex(K_BSY, 32'h1);
        ex(K_BV, 32'h80); ex(K_CNT, 32'h1);
        cyc();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5A;
        ex(K_RD0, BYP ? 32'h5A : 32'hA5);
        ex(K_BSY, BYP ? 32'h0 : 32'h1);
        ex(K_CNT, 32'h1);
        cyc();
        wr_en = 1'b0;
        ex(K_RD0, 32'h5A); ex(K_BV, 32'h0); ex(K_CNT, 32'h0);

        // Issue and write to different registers; write to a non-pending reg
        cyc();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h77;
        rd_addr = {5'd9, 5'd10};
        cyc();
        iss_en = 1'b0; wr_en = 1'b0;
        ex(K_RD0, 32'h77); ex(K_BSY, 32'h2);
        ex(K_BV, 32'h0000_0200); ex(K_CNT, 32'h1);

        // Issue every writable register; r9 is already pending
        for (int i = 1; i < 32; i++) begin
            cyc();
            iss_en = 1'b1; iss_addr = 5'(i);
            ex(K_CNT, (i <= 9) ? 32'(i) : 32'(i - 1));
        end
        cyc();
        iss_en = 1'b0;
        ex(K_CNT, 32'd31); ex(K_BV, 32'hFFFF_FFFE);

        // Partial drain, then reset overriding simultaneous issue and write
        cyc();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        cyc();
        ex(K_CNT, 32'd30); ex(K_BV, 32'hFFFF_FFEE);
        wr_addr = 5'd5; wr_data = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd4; rst = 1'b1;
        rd_addr = {5'd10, 5'd4};
        cyc();
        rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
        rd_addr = {5'd5, 5'd4};
        ex(K_CNT, 32'h0); ex(K_BV, 32'h0);
        ex(K_RD0, 32'h0); ex(K_RD1, 32'h0); ex(K_BSY, 32'h0);

        // Second instance: r0 ordinary, aliasing ports, out-of-range address
        cyc();
        wr_en2 = 1'b1; wr_addr2 = 5'd0; wr_data2 = 32'hFFFFFFFF;
        cyc();
        wr_addr2 = 5'd1; wr_data2 = 32'h11111111;
        cyc();
        wr_addr2 = 5'd2; wr_data2 = 32'h22222222;
        cyc();
        wr_addr2 = 5'd30; wr_data2 = 32'h00000BAD;
        iss_en2 = 1'b1; iss_addr2 = 5'd25;
        cyc();
        wr_en2 = 1'b0; iss_addr2 = 5'd1;
        cyc();
        iss_en2 = 1'b0;
        rd_addr2 = {5'd30, 5'd2, 5'd1, 5'd1};
        ex(K2_RD0, 32'h11111111); ex(K2_RD1, 32'h11111111);
        ex(K2_RD2, 32'h22222222); ex(K2_RD3, 32'h0);
        ex(K2_BSY, 32'h3); ex(K2_CNT, 32'h1); ex(K2_BV, 32'h2);
        cyc();
        rd_addr2 = {5'd0, 5'd2, 5'd1, 5'd23};
        ex(K2_RD3, 32'hFFFFFFFF); ex(K2_RD0, 32'h0);
        ex(K2_BSY, 32'h2);

        cyc();
        @(posedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
